// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
//   - opcode encodings decoded in DECODE
//   - FSM state encoding (13 used codes out of 16)
//   - alu_op, alu_src_b and pc_source field encodings
//   - ctrl_t: the full control word produced by mc_ctrl_outdec
package mips_ctrl_pkg;

  localparam int unsigned OP_BITS  = 6;
  localparam int unsigned AOP_BITS = 2;
  localparam int unsigned ST_BITS  = 4;

  localparam logic [OP_BITS-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_BITS-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_BITS-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_BITS-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_BITS-1:0] OP_J     = 6'b000010;
  localparam logic [OP_BITS-1:0] OP_ADDI  = 6'b001000;

  localparam logic [AOP_BITS-1:0] ALU_ADD   = 2'b00;
  localparam logic [AOP_BITS-1:0] ALU_SUB   = 2'b01;
  localparam logic [AOP_BITS-1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  typedef enum logic [ST_BITS-1:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StExc    = 4'd12
  } state_e;

  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [AOP_BITS-1:0] alu_op;
    logic [1:0]          pc_source;
    logic                exception;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // lw and sw share the address-calculation step.
  function automatic logic is_mem_op(logic [OP_BITS-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode for multicycle_control.
// Moore decode of the state, except ir_write/pc_write in FETCH, which only fire
// in the cycle memory delivers the instruction.
// Optional feature macro: MC_CTRL_EXC_EN (decodes the trap state).
// Ports:
//   state      in  current FSM state
//   mem_ready  in  memory access completes this cycle
//   ctrl       out packed ctrl_t control word
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [ST_BITS-1:0] state,
  input  logic               mem_ready,
  output logic [CTRL_W-1:0]  ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      StDecode: begin
        // Branch target computed speculatively while the opcode is decoded.
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
      end
      StAluWb: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      StAddiWb: begin
        c.reg_write = 1'b1;
      end
`ifdef MC_CTRL_EXC_EN
      StExc: begin
        c.exception = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_TRAP;
      end
`endif
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over a shared memory and a single ALU, with
// memory wait-states via mem_ready and addi support.
// Optional feature macro: MC_CTRL_EXC_EN -- illegal opcodes trap through an
// EXC state (exception=1, pc_write=1, pc_source=11); otherwise they return to
// FETCH and exception stays 0.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   opcode           IR[31:26], valid from DECODE onward
//   mem_ready        memory access completes this cycle
//   pc_write .. exception  datapath enables and mux selects (all 0 in reset)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                exception
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_word;
  ctrl_t              cw;
  ctrl_t              cw_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (is_mem_op(opcode)) begin
          state_d = StMemAdr;
        end else begin
          case (opcode)
            OP_RTYPE: state_d = StExec;
            OP_BEQ:   state_d = StBranch;
            OP_J:     state_d = StJump;
            OP_ADDI:  state_d = StAddiEx;
`ifdef MC_CTRL_EXC_EN
            default:  state_d = StExc;
`else
            default:  state_d = StFetch;
`endif
          endcase
        end
      end
      // Only lw/sw reach MEMADR, so anything but lw is a store.
      StMemAdr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      default:  state_d = StFetch;  // EXC and unused encodings
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_word)
  );

  assign cw = ctrl_t'(ctrl_word);
  // The state register already sits in FETCH during reset; mask its decode so
  // no memory request leaves the block until reset is released.
  assign cw_out = reset ? '0 : cw;

  assign pc_write      = cw_out.pc_write;
  assign pc_write_cond = cw_out.pc_write_cond;
  assign i_or_d        = cw_out.i_or_d;
  assign mem_read      = cw_out.mem_read;
  assign mem_write     = cw_out.mem_write;
  assign ir_write      = cw_out.ir_write;
  assign mem_to_reg    = cw_out.mem_to_reg;
  assign reg_dst       = cw_out.reg_dst;
  assign reg_write     = cw_out.reg_write;
  assign alu_src_a     = cw_out.alu_src_a;
  assign alu_src_b     = cw_out.alu_src_b;
  assign alu_op        = cw_out.alu_op;
  assign pc_source     = cw_out.pc_source;
  assign exception     = cw_out.exception;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded by
// the bench into its expected per-cycle control vectors (from opcode class and
// wait counts), which are then played against the DUT cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, exception;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [16:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .exception     (exception)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, exception};

  // Bench-side bit layout of obs.
  localparam logic [16:0] PCW = 17'h10000;
  localparam logic [16:0] PWC = 17'h08000;
  localparam logic [16:0] IOD = 17'h04000;
  localparam logic [16:0] MR  = 17'h02000;
  localparam logic [16:0] MW  = 17'h01000;
  localparam logic [16:0] IRW = 17'h00800;
  localparam logic [16:0] M2R = 17'h00400;
  localparam logic [16:0] RD  = 17'h00200;
  localparam logic [16:0] RW  = 17'h00100;
  localparam logic [16:0] SA  = 17'h00080;
  localparam logic [16:0] EX  = 17'h00001;

  // Expected control word for each step of an instruction.
  localparam logic [16:0] F_WAIT = MR | (17'd1 << 5);
  localparam logic [16:0] F_GO   = MR | (17'd1 << 5) | IRW | PCW;
  localparam logic [16:0] DEC    = 17'd3 << 5;
  localparam logic [16:0] MADR   = SA | (17'd2 << 5);
  localparam logic [16:0] MRD    = MR | IOD;
  localparam logic [16:0] MWB    = RW | M2R;
  localparam logic [16:0] MWR    = MW | IOD;
  localparam logic [16:0] EXE    = SA | (17'd2 << 3);
  localparam logic [16:0] AWB    = RD | RW;
  localparam logic [16:0] BR     = SA | (17'd1 << 3) | PWC | (17'd1 << 1);
  localparam logic [16:0] JMP    = PCW | (17'd2 << 1);
  localparam logic [16:0] AEX    = SA | (17'd2 << 5);
  localparam logic [16:0] AIWB   = RW;
  localparam logic [16:0] EXC    = EX | PCW | (17'd3 << 1);

  logic [16:0] exp_q[$];
  logic        mr_q[$];
  logic [5:0]  op_q[$];

  task automatic check(input string tag, input logic [16:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [16:0] e, input logic mr, input logic [5:0] op);
    exp_q.push_back(e);
    mr_q.push_back(mr);
    op_q.push_back(op);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // nf = fetch wait cycles, nm = load/store wait cycles. mem_ready is random
  // wherever no memory access is pending; opcode is random during fetch.
  task automatic instr(input logic [5:0] op, input int nf, input int nm);
    for (int i = 0; i < nf; i++) push(F_WAIT, 1'b0, 6'($urandom));
    push(F_GO, 1'b1, 6'($urandom));
    push(DEC, rb(), op);
    case (op)
      6'b100011: begin
        push(MADR, rb(), op);
        for (int i = 0; i < nm; i++) push(MRD, 1'b0, op);
        push(MRD, 1'b1, op);
        push(MWB, rb(), op);
      end
      6'b101011: begin
        push(MADR, rb(), op);
        for (int i = 0; i < nm; i++) push(MWR, 1'b0, op);
        push(MWR, 1'b1, op);
      end
      6'b000000: begin
        push(EXE, rb(), op);
        push(AWB, rb(), op);
      end
      6'b000100: push(BR, rb(), op);
      6'b000010: push(JMP, rb(), op);
      6'b001000: begin
        push(AEX, rb(), op);
        push(AIWB, rb(), op);
      end
      default: begin
`ifdef MC_CTRL_EXC_EN
        push(EXC, rb(), op);
`endif
      end
    endcase
  endtask

  // Plays n queued cycles (all of them when n < 0).
  task automatic run(input int n, input string tag);
    int k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front();
      opcode    = op_q.pop_front();
      #1;
      check($sformatf("%s[%0d]", tag, k), exp_q.pop_front());
      k++;
    end
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

    reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
    #1;
    check("reset_init", 17'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_release", F_WAIT);

    instr(6'b000000, 0, 0); run(-1, "add");
    instr(6'b100011, 0, 2); run(-1, "lw_wait2");
    instr(6'b000100, 0, 0); run(-1, "beq");
    instr(6'b000010, 0, 0); run(-1, "j");
    instr(6'b000000, 3, 0); run(-1, "fetch_wait3");
    instr(6'b111111, 0, 0); run(-1, "illegal");
    instr(6'b101011, 0, 1); run(-1, "sw_wait1");
    instr(6'b001000, 1, 0); run(-1, "addi");

    // Reset in the middle of a stalled load.
    instr(6'b100011, 0, 5);
    run(5, "lw_pre_reset");
    #2 reset = 1'b1;
    #1;
    check("reset_mid_memrd", 17'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("reset_hold", 17'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_mid_release", F_WAIT);
    exp_q.delete(); mr_q.delete(); op_q.delete();

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'($urandom);
        if (legal(op)) op = 6'b111111;
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run(-1, $sformatf("rnd%0d_op%02h", t, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
